// File: rtl/mem_port_arbiter_if.sv
// Processor-side and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the surrounding system drives it as master.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 InstrReq;
    logic [WORD_SIZE-1:0] InstrAddr;
    logic                 InstrWaitreq;
    logic [WORD_SIZE-1:0] InstrIn;

    logic                 ReadData;
    logic                 WriteData;
    logic [WORD_SIZE-1:0] DataAddr;
    logic [WORD_SIZE-1:0] DataOut;
    logic                 DataWaitreq;
    logic [WORD_SIZE-1:0] DataIn;

    logic [WORD_SIZE-1:0] MemAddr;
    logic [WORD_SIZE-1:0] MemWriteData;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemWaitreq;
    logic [WORD_SIZE-1:0] MemReadData;
    logic                 MemReadValid;

    logic                 ProtoErr;

    modport slave (
        input  InstrReq, InstrAddr,
        input  ReadData, WriteData, DataAddr, DataOut,
        input  MemWaitreq, MemReadData, MemReadValid,
        output InstrWaitreq, InstrIn,
        output DataWaitreq, DataIn,
        output MemAddr, MemWriteData, MemRead, MemWrite,
        output ProtoErr
    );

    modport master (
        output InstrReq, InstrAddr,
        output ReadData, WriteData, DataAddr, DataOut,
        output MemWaitreq, MemReadData, MemReadValid,
        input  InstrWaitreq, InstrIn,
        input  DataWaitreq, DataIn,
        input  MemAddr, MemWriteData, MemRead, MemWrite,
        input  ProtoErr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins arbitration; a starvation counter eventually forces fetch through.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef logic [WORD_SIZE-1:0] word_t;

    logic          mem_read_q;
    logic          mem_write_q;
    word_t         mem_addr_q;
    word_t         mem_wdata_q;
    logic          slot_src;
    logic          data_issued;
    logic          instr_issued;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    tag_cnt;
    logic          tag0;
    logic          tag1;
    logic          proto_err_q;

    logic slot_free;
    logic rd_accept;
    logic wr_accept;
    logic tag_avail;
    logic tag_pop;
    logic rsp_instr;
    logic rsp_data;
    logic data_req;
    logic data_cand;
    logic instr_cand;
    logic starved;
    logic grant_instr;
    logic grant_data;
    logic data_done;
    logic instr_done;

    assign slot_free = !(mem_read_q || mem_write_q) || !bus.MemWaitreq;
    assign rd_accept = mem_read_q && !bus.MemWaitreq;
    assign wr_accept = mem_write_q && !bus.MemWaitreq;

    // Head of the tag FIFO names the owner of the next read response.
    assign tag_avail = (tag_cnt != 2'd0);
    assign tag_pop   = bus.MemReadValid && tag_avail;
    assign rsp_instr = tag_pop && tag0;
    assign rsp_data  = tag_pop && !tag0;

    assign data_req   = bus.ReadData || bus.WriteData;
    assign data_cand  = data_req && !data_issued;
    assign instr_cand = bus.InstrReq && !instr_issued;
    assign starved    = (starve_cnt == SW'(STARVE_LIMIT));

    assign grant_instr = slot_free && instr_cand
                      && (!data_cand || starved);
    assign grant_data  = slot_free && data_cand && !grant_instr;

    assign data_done  = wr_accept || rsp_data;
    assign instr_done = rsp_instr;

    assign bus.InstrWaitreq = bus.InstrReq && !instr_done;
    assign bus.InstrIn      = rsp_instr ? bus.MemReadData : '0;
    assign bus.DataWaitreq  = data_req && !data_done;
    assign bus.DataIn       = rsp_data ? bus.MemReadData : '0;

    assign bus.MemAddr      = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.ProtoErr     = proto_err_q;

    // Command slot: held while the memory stalls, reloaded on a grant.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            slot_src    <= 1'b0;
        end else if (slot_free) begin
            mem_read_q  <= grant_instr || (grant_data && !bus.WriteData);
            mem_write_q <= grant_data && bus.WriteData;
            unique case (1'b1)
                grant_instr: begin
                    mem_addr_q <= bus.InstrAddr;
                    slot_src   <= 1'b1;
                end
                grant_data: begin
                    mem_addr_q  <= bus.DataAddr;
                    mem_wdata_q <= bus.DataOut;
                    slot_src    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            instr_issued <= 1'b0;
            data_issued  <= 1'b0;
            starve_cnt   <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            proto_err_q <= bus.MemReadValid && !tag_avail;

            if (grant_instr)
                instr_issued <= 1'b1;
            else if (instr_done)
                instr_issued <= 1'b0;

            if (grant_data)
                data_issued <= 1'b1;
            else if (data_done)
                data_issued <= 1'b0;

            if (grant_instr)
                starve_cnt <= '0;
            else if (grant_data && instr_cand && !starved)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Two-entry tag FIFO; tag0 is the head. One read per source bounds it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag_cnt <= 2'd0;
            tag0    <= 1'b0;
            tag1    <= 1'b0;
        end else begin
            unique case ({rd_accept, tag_pop})
                2'b10: begin
                    if (tag_cnt == 2'd0)
                        tag0 <= slot_src;
                    else
                        tag1 <= slot_src;
                    tag_cnt <= tag_cnt + 2'd1;
                end
                2'b01: begin
                    tag0    <= tag1;
                    tag_cnt <= tag_cnt - 2'd1;
                end
                2'b11: begin
                    if (tag_cnt == 2'd1) begin
                        tag0 <= slot_src;
                    end else begin
                        tag0 <= tag1;
                        tag1 <= slot_src;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of both requesters, the arbiter rules and an in-order memory.
module tb_mem_port_arbiter;
    localparam int W     = 16;
    localparam int LIMIT = 4;

    logic Clock;
    logic Reset;

    mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE    (W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester intent
    bit         f_req;
    logic [W-1:0] f_addr;
    bit         d_rd;
    bit         d_wr;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_data;
    // Memory behaviour this cycle
    bit         mwait;
    bit         mvalid;
    logic [W-1:0] mrdata;
    logic [W-1:0] memq[$];

    // Expected arbiter-visible state
    bit         m_rd;
    bit         m_wr;
    bit         m_src;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    bit         m_iss_i;
    bit         m_iss_d;
    int         m_starve;
    bit         m_perr;
    bit         tagq[$];
    int         fetch_grants;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_rd     = 0;
        m_wr     = 0;
        m_src    = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_iss_i  = 0;
        m_iss_d  = 0;
        m_starve = 0;
        m_perr   = 0;
        tagq.delete();
        memq.delete();
    endtask

    task automatic drive();
        bus.InstrReq     = f_req;
        bus.InstrAddr    = f_addr;
        bus.ReadData     = d_rd;
        bus.WriteData    = d_wr;
        bus.DataAddr     = d_addr;
        bus.DataOut      = d_data;
        bus.MemWaitreq   = mwait;
        bus.MemReadValid = mvalid;
        bus.MemReadData  = mrdata;
    endtask

    task automatic mem(input bit w, input bit v, input logic [W-1:0] d);
        mwait  = w;
        mvalid = v;
        mrdata = d;
    endtask

    task automatic respond(input logic [W-1:0] d);
        mem(0, 1, d);
        if (memq.size() != 0)
            void'(memq.pop_front());
    endtask

    // Checks this cycle's outputs, then moves the model to the next cycle.
    task automatic model_cycle();
        bit free, acc_rd, acc_wr, have, ri, rdd, dd, ci, cd, gi, gd;
        free   = !(m_rd || m_wr) || !mwait;
        acc_rd = m_rd && !mwait;
        acc_wr = m_wr && !mwait;
        have   = tagq.size() != 0;
        ri     = mvalid && have && tagq[0];
        rdd    = mvalid && have && !tagq[0];
        dd     = acc_wr || rdd;

        check("InstrWaitreq", bus.InstrWaitreq, f_req && !ri);
        check("InstrIn", bus.InstrIn, ri ? mrdata : '0);
        check("DataWaitreq", bus.DataWaitreq, (d_rd || d_wr) && !dd);
        check("DataIn", bus.DataIn, rdd ? mrdata : '0);
        check("MemRead", bus.MemRead, m_rd);
        check("MemWrite", bus.MemWrite, m_wr);
        if (m_rd || m_wr)
            check("MemAddr", bus.MemAddr, m_addr);
        if (m_wr)
            check("MemWriteData", bus.MemWriteData, m_wdata);
        check("ProtoErr", bus.ProtoErr, m_perr);

        ci = f_req && !m_iss_i;
        cd = (d_rd || d_wr) && !m_iss_d;
        gi = free && ci && (!cd || m_starve == LIMIT);
        gd = free && cd && !gi;

        if (mvalid && have)
            void'(tagq.pop_front());
        if (acc_rd) begin
            tagq.push_back(m_src);
            memq.push_back(W'($urandom));
        end
        m_perr = mvalid && !have;

        if (free) begin
            m_rd = gi || (gd && !d_wr);
            m_wr = gd && d_wr;
            if (gi) begin
                m_addr = f_addr;
                m_src  = 1;
            end else if (gd) begin
                m_addr  = d_addr;
                m_wdata = d_data;
                m_src   = 0;
            end
        end

        if (ri) m_iss_i = 0;
        if (gi) m_iss_i = 1;
        if (dd) m_iss_d = 0;
        if (gd) m_iss_d = 1;

        if (gi) begin
            m_starve = 0;
            fetch_grants++;
        end else if (gd && ci && m_starve < LIMIT) begin
            m_starve++;
        end

        if (ri) f_req = 0;
        if (dd) begin
            d_rd = 0;
            d_wr = 0;
        end
    endtask

    task automatic settle();
        drive();
        #4;
    endtask

    task automatic advance();
        model_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        Reset = 1;
        drive();
        #2;
        check("rst MemRead", bus.MemRead, 1'b0);
        check("rst MemWrite", bus.MemWrite, 1'b0);
        check("rst ProtoErr", bus.ProtoErr, 1'b0);
        check("rst MemAddr", bus.MemAddr, 16'h0000);
        check("rst MemWriteData", bus.MemWriteData, 16'h0000);
        model_clear();
        @(posedge Clock);
        #1;
        Reset = 0;
    endtask

    task automatic gen();
        int k;
        if (!f_req && $urandom_range(2, 0) == 0) begin
            f_req  = 1;
            f_addr = W'($urandom);
        end
        if (!d_rd && !d_wr && $urandom_range(1, 0) == 0) begin
            k      = $urandom_range(3, 0);
            d_rd   = (k != 1);
            d_wr   = (k == 1) || (k == 2);
            d_addr = W'($urandom);
            d_data = W'($urandom);
        end
        mwait  = ($urandom_range(3, 0) == 0);
        mrdata = W'($urandom);
        mvalid = 0;
        if (memq.size() != 0 && $urandom_range(2, 0) != 0) begin
            mvalid = 1;
            mrdata = memq.pop_front();
        end else if (memq.size() == 0 && $urandom_range(59, 0) == 0) begin
            mvalid = 1;
        end
    endtask

    initial begin
        int fg0;
        Reset  = 1;
        f_req  = 0;
        f_addr = '0;
        d_rd   = 0;
        d_wr   = 0;
        d_addr = '0;
        d_data = '0;
        mem(0, 0, 0);
        fetch_grants = 0;
        #1;
        do_reset();

        // Lone fetch: command next cycle, data the cycle after.
        f_req  = 1;
        f_addr = 16'h0010;
        step();
        mem(0, 0, 0);
        settle();
        check("t1 MemRead", bus.MemRead, 1'b1);
        check("t1 MemAddr", bus.MemAddr, 16'h0010);
        advance();
        respond(16'h1234);
        settle();
        check("t1 InstrWaitreq", bus.InstrWaitreq, 1'b0);
        check("t1 InstrIn", bus.InstrIn, 16'h1234);
        advance();
        mem(0, 0, 0);
        step();

        // Fetch and load together: load goes first.
        f_req  = 1;
        f_addr = 16'h0010;
        d_rd   = 1;
        d_addr = 16'h0200;
        step();
        settle();
        check("t2 load addr", bus.MemAddr, 16'h0200);
        check("t2 load rd", bus.MemRead, 1'b1);
        advance();
        respond(16'hAAAA);
        settle();
        check("t2 fetch addr", bus.MemAddr, 16'h0010);
        check("t2 DataIn", bus.DataIn, 16'hAAAA);
        advance();
        respond(16'h5555);
        settle();
        check("t2 InstrIn", bus.InstrIn, 16'h5555);
        advance();
        mem(0, 0, 0);
        step();

        // Store held through three stalled cycles.
        d_wr   = 1;
        d_addr = 16'h0300;
        d_data = 16'hBEEF;
        step();
        for (int i = 0; i < 3; i++) begin
            mem(1, 0, 0);
            settle();
            check("t3 hold data", bus.MemWriteData, 16'hBEEF);
            check("t3 hold wait", bus.DataWaitreq, 1'b1);
            advance();
        end
        mem(0, 0, 0);
        settle();
        check("t3 accept addr", bus.MemAddr, 16'h0300);
        check("t3 accept wait", bus.DataWaitreq, 1'b0);
        advance();
        step();

        // Read and write together behave as a write.
        d_rd   = 1;
        d_wr   = 1;
        d_addr = 16'h0040;
        d_data = 16'h00FF;
        step();
        settle();
        check("t6 MemWrite", bus.MemWrite, 1'b1);
        check("t6 MemRead", bus.MemRead, 1'b0);
        check("t6 data", bus.MemWriteData, 16'h00FF);
        advance();
        step();

        // Reset with a load in flight; the late response is an error.
        d_rd   = 1;
        d_addr = 16'h0200;
        step();
        step();
        do_reset();
        mem(1, 0, 0);
        step();
        mem(1, 1, 16'h7777);
        settle();
        check("t5 no drop", bus.DataWaitreq, 1'b1);
        advance();
        mem(1, 0, 0);
        settle();
        check("t5 ProtoErr", bus.ProtoErr, 1'b1);
        advance();
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            gen();
            step();
        end

        // Drain: a pending fetch must be granted within a bounded time.
        fg0   = fetch_grants;
        f_req = 1;
        f_addr = 16'h0ABC;
        for (int c = 0; c < 40 && fetch_grants == fg0; c++) begin
            if (!d_rd && !d_wr) begin
                d_rd   = 1;
                d_addr = W'($urandom);
            end
            mwait  = 0;
            mvalid = 0;
            mrdata = '0;
            if (memq.size() != 0) begin
                mvalid = 1;
                mrdata = memq.pop_front();
            end
            step();
        end
        check("fetch not starved", fetch_grants > fg0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
